// File: rtl/adpcm_pkg.sv
// Shared IMA/DVI ADPCM constants: step table, index adjustment, limits and FSM states.
// Used by both the ADPCM encoder and decoder.
package adpcm_pkg;

    localparam int unsigned IDX_MAX = 88;

    localparam logic signed [15:0] PCM_MAX = 16'sh7FFF;
    localparam logic signed [15:0] PCM_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_UPD
    } adpcm_state_t;

    localparam logic [14:0] STEP_TABLE [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    // Indexed by code magnitude; small magnitudes shrink the step, large ones grow it.
    localparam logic signed [4:0] IDX_ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational step-index to quantiser-step lookup.
// Out-of-range indices return the largest step.
module adpcm_step_rom #(
    parameter int unsigned IDX_W = 7
) (
    input  logic [IDX_W-1:0] index,
    output logic [14:0]      step
);
    import adpcm_pkg::*;

    always_comb begin
        step = STEP_TABLE[IDX_MAX];
        if (index <= IDX_W'(IDX_MAX)) begin
            step = STEP_TABLE[index];
        end
    end

endmodule

// File: rtl/adpcm_decoder.sv
// IMA/DVI ADPCM decoder: one 4-bit code to one signed PCM sample every 5 clocks.
// Optional first-order delta-sigma output when ADPCM_DEC_PDM_OUT_EN is defined.
module adpcm_decoder #(
    parameter int unsigned PCM_W = 16,
    parameter int unsigned IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             code_valid,
    input  logic [3:0]       code_in,
    output logic             code_ready,
    output logic             pcm_valid,
    output logic [PCM_W-1:0] pcm_out,
    output logic [IDX_W-1:0] step_index
`ifdef ADPCM_DEC_PDM_OUT_EN
    ,
    output logic             pdm_out
`endif
);
    import adpcm_pkg::*;

    localparam int unsigned SUM_W  = PCM_W + 2;
    localparam int unsigned DIFF_W = 17;

    adpcm_state_t state, state_nxt;

    logic [1:0]              cnt;
    logic [3:0]              code_r;
    logic [14:0]             step_r;
    logic [14:0]             rom_step;
    logic [DIFF_W-1:0]       diff;
    logic [DIFF_W-1:0]       addend;
    logic signed [SUM_W-1:0] pred_ext;
    logic signed [SUM_W-1:0] diff_ext;
    logic signed [SUM_W-1:0] sum;
    logic [PCM_W-1:0]        pcm_sat;
    logic signed [IDX_W:0]   idx_sum;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    accept;

    adpcm_step_rom #(.IDX_W(IDX_W)) u_step_rom (
        .index (step_index),
        .step  (rom_step)
    );

    // rst_n is folded in so the handshake stays closed while reset is held.
    assign code_ready = rst_n && enable && (state == ST_IDLE);
    assign accept     = code_ready && code_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (code_valid) state_nxt = ST_CALC;
                ST_CALC: if (cnt == 2'd2) state_nxt = ST_UPD;
                ST_UPD:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // One magnitude bit per CALC cycle, MSB first.
    always_comb begin
        addend = '0;
        case (cnt)
            2'd0:    if (code_r[2]) addend = DIFF_W'(step_r);
            2'd1:    if (code_r[1]) addend = DIFF_W'(step_r >> 1);
            default: if (code_r[0]) addend = DIFF_W'(step_r >> 2);
        endcase
    end

    always_comb begin
        pred_ext = SUM_W'($signed(pcm_out));
        diff_ext = $signed(SUM_W'(diff));
        sum      = code_r[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
        if (sum > $signed(SUM_W'(PCM_MAX))) begin
            pcm_sat = PCM_W'(PCM_MAX);
        end else if (sum < $signed(SUM_W'(PCM_MIN))) begin
            pcm_sat = PCM_W'(PCM_MIN);
        end else begin
            pcm_sat = sum[PCM_W-1:0];
        end
    end

    always_comb begin
        idx_sum = $signed({1'b0, step_index}) + (IDX_W+1)'(IDX_ADJ[code_r[2:0]]);
        if (idx_sum[IDX_W]) begin
            idx_nxt = '0;
        end else if (idx_sum > $signed((IDX_W+1)'(IDX_MAX))) begin
            idx_nxt = IDX_W'(IDX_MAX);
        end else begin
            idx_nxt = idx_sum[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_out    <= '0;
            step_index <= '0;
            pcm_valid  <= 1'b0;
            cnt        <= '0;
            code_r     <= '0;
            step_r     <= '0;
            diff       <= '0;
        end else if (!enable) begin
            pcm_out    <= '0;
            step_index <= '0;
            pcm_valid  <= 1'b0;
            cnt        <= '0;
        end else begin
            pcm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        code_r <= code_in;
                        step_r <= rom_step;
                        diff   <= DIFF_W'(rom_step >> 3);
                        cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    diff <= diff + addend;
                    cnt  <= cnt + 2'd1;
                end
                ST_UPD: begin
                    pcm_out    <= pcm_sat;
                    step_index <= idx_nxt;
                    pcm_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ADPCM_DEC_PDM_OUT_EN
    // Offset-binary input; the carry out of the 16-bit accumulator is the bitstream.
    logic [16:0] pdm_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_acc <= '0;
        end else if (!enable) begin
            pdm_acc <= '0;
        end else begin
            pdm_acc <= {1'b0, pdm_acc[15:0]} + {1'b0, pcm_out[15:0] ^ 16'h8000};
        end
    end

    assign pdm_out = pdm_acc[16];
`endif

endmodule

// File: tb/tb_adpcm_decoder.sv
// Directed-vector bench for adpcm_decoder with hand-computed expected samples.
// Define ADPCM_DEC_PDM_OUT_EN to also exercise the delta-sigma output.
module tb_adpcm_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        code_valid = 1'b0;
    logic [3:0]  code_in = '0;
    logic        code_ready;
    logic        pcm_valid;
    logic [15:0] pcm_out;
    logic [6:0]  step_index;
`ifdef ADPCM_DEC_PDM_OUT_EN
    logic        pdm_out;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    adpcm_decoder #(.PCM_W(16), .IDX_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .code_valid (code_valid),
        .code_in    (code_in),
        .code_ready (code_ready),
        .pcm_valid  (pcm_valid),
        .pcm_out    (pcm_out),
        .step_index (step_index)
`ifdef ADPCM_DEC_PDM_OUT_EN
        ,
        .pdm_out    (pdm_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        code_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input logic [3:0] c);
        int b;
        b = 0;
        code_in = c;
        code_valid = 1'b1;
        while (!code_ready && b < 20) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (!code_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic wait_pcm(output int l);
        l = 0;
        while (!pcm_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!pcm_valid) chk("pcm_timeout", 32'd0, 32'd1);
    endtask

    task automatic decode(input logic [3:0] c);
        send(c);
        wait_pcm(lat);
    endtask

    task automatic count_pcm(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (pcm_valid) n++;
            @(posedge clk);
            #1;
        end
    endtask

`ifdef ADPCM_DEC_PDM_OUT_EN
    task automatic chk_pdm(input string tag, input int pcm_signed);
        int ones;
        int exp_ones;
        ones = 0;
        exp_ones = ((pcm_signed + 32768) * 1024) / 65536;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk);
            #1;
            if (pdm_out) ones++;
        end
        chk(tag, 32'(ones >= exp_ones - 1 && ones <= exp_ones + 1), 32'd1);
    endtask
`endif

    initial begin
        int acc_n;
        int pv_n;
        int last;
        int gap_bad;
        int n;

        // Reset state, with enable high and reset still asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(code_ready), 32'd0);
        chk("rst_valid", 32'(pcm_valid), 32'd0);
        chk("rst_pcm", 32'(pcm_out), 32'd0);
        chk("rst_idx", 32'(step_index), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(code_ready), 32'd1);

        // 1: 0111 from reset -> 0+7+3+1 = 11, index 8, four edges after accept
        decode(4'b0111);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_pcm", 32'(pcm_out), 32'd11);
        chk("t1_idx", 32'(step_index), 32'd8);
        @(posedge clk);
        #1;
        chk("t1_single", 32'(pcm_valid), 32'd0);
        chk("t1_hold", 32'(pcm_out), 32'd11);
`ifdef ADPCM_DEC_PDM_OUT_EN
        chk_pdm("pdm_11", 11);
`endif

        // 2: 1000 from reset -> diff 0, index clamps at 0; then a short hand-worked run
        do_reset();
        decode(4'b1000);
        chk("t2_pcm", 32'(pcm_out), 32'd0);
        chk("t2_idx", 32'(step_index), 32'd0);
        decode(4'b0100);            // step 7: 0+7
        chk("t2b_pcm", 32'(pcm_out), 32'd7);
        chk("t2b_idx", 32'(step_index), 32'd2);
        decode(4'b1011);            // step 9: 1+4+2 subtracted
        chk("t2c_pcm", 32'(pcm_out), 32'd0);
        chk("t2c_idx", 32'(step_index), 32'd1);
        decode(4'b0101);            // step 8: 1+8+2
        chk("t2d_pcm", 32'(pcm_out), 32'd11);
        chk("t2d_idx", 32'(step_index), 32'd5);

        // 3: saturation high, index clamp high, then large negative step
        do_reset();
        for (int i = 0; i < 11; i++) decode(4'b0111);
        chk("t3_idx11", 32'(step_index), 32'd88);
        for (int i = 11; i < 200; i++) decode(4'b0111);
        chk("t3_idx", 32'(step_index), 32'd88);
        chk("t3_pcm_max", 32'(pcm_out), 32'h7FFF);
`ifdef ADPCM_DEC_PDM_OUT_EN
        chk_pdm("pdm_max", 32767);
`endif
        decode(4'b1111);            // 32767 - 61436
        chk("t3_neg", 32'(pcm_out), 32'h9003);
        chk("t3_idx_neg", 32'(step_index), 32'd88);
        decode(4'b1111);
        chk("t3_pcm_min", 32'(pcm_out), 32'h8000);

        // 4: code_valid held high -> accept every 5th clock, one pcm_valid per accept
        do_reset();
        code_in = 4'b0000;
        code_valid = 1'b1;
        acc_n = 0;
        pv_n = 0;
        last = -5;
        gap_bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (code_ready) begin
                acc_n++;
                if (k - last != 5) gap_bad++;
                last = k;
            end
            if (pcm_valid) pv_n++;
            @(posedge clk);
            #1;
        end
        code_valid = 1'b0;
        count_pcm(10, n);
        pv_n += n;
        chk("t4_accepts", 32'(acc_n), 32'd10);
        chk("t4_gap", 32'(gap_bad), 32'd0);
        chk("t4_pcm_cnt", 32'(pv_n), 32'd10);

        // 5a: enable dropped mid-CALC
        do_reset();
        decode(4'b0111);
        chk("t5_pre_pcm", 32'(pcm_out), 32'd11);
        send(4'b0111);
        @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        chk("t5_en_ready", 32'(code_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_en_pcm", 32'(pcm_out), 32'd0);
        chk("t5_en_idx", 32'(step_index), 32'd0);
        chk("t5_en_valid", 32'(pcm_valid), 32'd0);
        enable = 1'b1;
        count_pcm(10, n);
        chk("t5_en_nostrobe", 32'(n), 32'd0);
        chk("t5_en_ready2", 32'(code_ready), 32'd1);

        // 5b: async reset mid-decode
        decode(4'b0111);
        chk("t5_pre2_pcm", 32'(pcm_out), 32'd11);
        send(4'b0111);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pcm", 32'(pcm_out), 32'd0);
        chk("t5_rst_idx", 32'(step_index), 32'd0);
        chk("t5_rst_ready", 32'(code_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_pcm(10, n);
        chk("t5_rst_nostrobe", 32'(n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
